// File: rtl/pwm_pkg.sv
// Shared constants for the PWM duty ramp controller: default widths and
// the ramp sequencer state encoding.
package pwm_pkg;

    localparam int PWM_DW = 16;
    localparam int PWM_IW = 8;

    typedef logic [1:0] pwm_state_t;

    localparam pwm_state_t ST_IDLE = 2'd0;
    localparam pwm_state_t ST_RAMP = 2'd1;
    localparam pwm_state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/pwm_period_tick.sv
// Period counter mirroring the PWM core: counts 0..period and wraps,
// flagging the last count of each period as a tick. A new period value
// is only adopted at the wrap so a running period is never cut short.
module pwm_period_tick
    import pwm_pkg::*;
#(
    parameter int DW = PWM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] period_reg,
    output logic          tick
);

    logic [DW-1:0] cnt;
    logic [DW-1:0] per_q;

    assign tick = en & (cnt == per_q);

    // Count while enabled, hold otherwise; resample the period at each wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            per_q <= period_reg;
        end else if (en) begin
            if (cnt == per_q) begin
                cnt   <= '0;
                per_q <= period_reg;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty ramp controller: walks o_DC toward a requested target in fixed
// steps, one step every `interval` PWM periods, always on a period
// boundary so the PWM core never sees a mid-period duty change.
module pwm_duty_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int DW = PWM_DW,
    parameter int IW = PWM_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] period_reg,
    input  logic [DW-1:0] tgt_duty,
    input  logic          tgt_valid,
    input  logic [DW-1:0] step,
    input  logic [IW-1:0] interval,
    output logic [DW-1:0] o_DC,
    output logic          o_DC_valid,
    output logic          busy,
    output logic          done
);

    pwm_state_t    state;
    logic [DW-1:0] tgt_q;
    logic [DW-1:0] step_q;
    logic [IW-1:0] ivl_q;
    logic [IW-1:0] icnt;
    logic [DW-1:0] dc_next;
    logic          tick;
    logic          load;

    // A target above the period could never be reached by the PWM core
    function automatic logic [DW-1:0] clamp_tgt(input logic [DW-1:0] req,
                                                input logic [DW-1:0] per);
        return (req > per) ? per : req;
    endfunction

    // Interval 0 and 1 both mean one step per period
    function automatic logic [IW-1:0] reload_val(input logic [IW-1:0] ivl);
        return (ivl == '0) ? '0 : ivl - IW'(1);
    endfunction

    // One saturating step toward the target; the sum is formed one bit
    // wider so a large step cannot wrap past the target
    function automatic logic [DW-1:0] sat_step(input logic [DW-1:0] cur,
                                               input logic [DW-1:0] tgt,
                                               input logic [DW-1:0] stp);
        logic [DW:0] sum;
        sum = {1'b0, cur} + {1'b0, stp};
        if (stp == '0)
            return tgt;
        if (cur < tgt)
            return (sum >= {1'b0, tgt}) ? tgt : sum[DW-1:0];
        return ((cur - tgt) <= stp) ? tgt : cur - stp;
    endfunction

    pwm_period_tick #(.DW(DW)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period_reg (period_reg),
        .tick       (tick)
    );

    assign load       = en & tgt_valid;
    assign dc_next    = sat_step(o_DC, tgt_q, step_q);
    assign o_DC_valid = (state != ST_IDLE);
    assign busy       = (state == ST_RAMP);

    // Command registers: captured on every accepted target strobe
    always_ff @(posedge clk) begin
        if (load) begin
            tgt_q  <= clamp_tgt(tgt_duty, period_reg);
            step_q <= step;
            ivl_q  <= interval;
        end
    end

    // Sequencer: a new command beats any pending step; steps land on ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            o_DC  <= '0;
            done  <= 1'b0;
            icnt  <= '0;
        end else begin
            done <= 1'b0;
            if (!en) begin
                state <= ST_IDLE;
            end else if (tgt_valid) begin
                icnt  <= reload_val(interval);
                state <= ST_RAMP;
            end else if (state == ST_RAMP) begin
                if (o_DC == tgt_q) begin
                    state <= ST_HOLD;
                    done  <= 1'b1;
                end else if (tick) begin
                    if (icnt == '0) begin
                        o_DC <= dc_next;
                        icnt <= reload_val(ivl_q);
                        if (dc_next == tgt_q) begin
                            state <= ST_HOLD;
                            done  <= 1'b1;
                        end
                    end else begin
                        icnt <= icnt - IW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Bench for pwm_duty_ramp_ctrl. Each command is planned up front from the
// ramp rules (tick every period+1 enabled cycles, one step per interval
// ticks, saturating at the clamped target); the planned duty values, the
// edges they appear on and the done edge are queued, and a monitor pops
// and compares whenever o_DC changes or done rises.
module tb_pwm_duty_ramp_ctrl;

    localparam int DW = 16;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] period_reg;
    logic [DW-1:0] tgt_duty;
    logic          tgt_valid;
    logic [DW-1:0] step;
    logic [IW-1:0] interval;
    logic [DW-1:0] o_DC;
    logic          o_DC_valid;
    logic          busy;
    logic          done;

    pwm_duty_ramp_ctrl #(.DW(DW), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period_reg (period_reg),
        .tgt_duty   (tgt_duty),
        .tgt_valid  (tgt_valid),
        .step       (step),
        .interval   (interval),
        .o_DC       (o_DC),
        .o_DC_valid (o_DC_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int nedges   = 0;   // posedges seen by the monitor
    int ed       = 0;   // index of the next posedge, stimulus side
    int ecnt     = 0;   // enabled, non-reset edges since the last reset
    int per      = 0;   // period in force since the last reset
    int mdc      = 0;   // model duty after everything already queued
    int ev_q[$];
    int ee_q[$];
    int done_q[$];
    int plan_v[$];
    int plan_e[$];
    int plan_done;
    bit mon_en = 1'b0;
    logic [DW-1:0] last_dc;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        if (rst) ecnt = 0;
        else if (en) ecnt++;
        ed++;
        #1;
    endtask

    // Full trajectory of a command issued at edge e0, assuming en stays high
    task automatic plan(input int td, input int stp, input int itv, input int e0);
        int tgt, n, d, j, tk;
        tgt = (td > per) ? per : td;
        n   = (itv == 0) ? 1 : itv;
        d   = mdc;
        j   = 0;
        tk  = 0;
        plan_v.delete();
        plan_e.delete();
        while (d != tgt) begin
            j++;
            if ((ecnt + j) % (per + 1) == per) begin
                tk++;
                if (tk % n == 0) begin
                    if (stp == 0)     d = tgt;
                    else if (d < tgt) d = (d + stp >= tgt) ? tgt : d + stp;
                    else              d = (d - tgt <= stp) ? tgt : d - stp;
                    plan_v.push_back(d);
                    plan_e.push_back(e0 + j);
                end
            end
        end
        plan_done = (plan_e.size() == 0) ? e0 + 1 : plan_e[$];
    endtask

    // Issue a command; the next action lands on edge lim (cut) or the
    // ramp is allowed to finish. Only events before lim are expected.
    task automatic issue(input int td, input int stp, input int itv,
                         input int cut_steps, input int cut_rel);
        int e0, lim;
        e0 = ed;
        plan(td, stp, itv, e0);
        if (cut_steps > 0 && plan_e.size() >= cut_steps)
            lim = plan_e[cut_steps-1] + 1 + cut_rel;
        else if (cut_rel > 0)
            lim = e0 + cut_rel;
        else
            lim = plan_done + 3;
        foreach (plan_e[i]) begin
            if (plan_e[i] < lim) begin
                ev_q.push_back(plan_v[i]);
                ee_q.push_back(plan_e[i]);
                mdc = plan_v[i];
            end
        end
        if (plan_done < lim) done_q.push_back(plan_done);
        tgt_duty  = DW'(td);
        step      = DW'(stp);
        interval  = IW'(itv);
        tgt_valid = 1'b1;
        clk1();
        tgt_valid = 1'b0;
        chk("busy_after_load", int'(busy), 1);
        chk("valid_after_load", int'(o_DC_valid), 1);
        while (ed < lim) clk1();
    endtask

    task automatic en_drop(input int n);
        en = 1'b0;
        clk1();
        chk("valid_en_off", int'(o_DC_valid), 0);
        chk("busy_en_off", int'(busy), 0);
        chk("dc_held_en_off", int'(o_DC), mdc);
        tgt_duty  = DW'((mdc == 0) ? per : 0);
        step      = '0;
        interval  = '0;
        tgt_valid = 1'b1;
        clk1();
        tgt_valid = 1'b0;
        repeat (n) clk1();
        chk("valid_idle_en_off", int'(o_DC_valid), 0);
        en = 1'b1;
    endtask

    task automatic do_reset(input int p, input int n);
        if (mdc != 0) begin
            ev_q.push_back(0);
            ee_q.push_back(ed);
        end
        mdc        = 0;
        per        = p;
        period_reg = DW'(p);
        rst        = 1'b1;
        clk1();
        chk("rst_dc", int'(o_DC), 0);
        chk("rst_valid", int'(o_DC_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (n - 1) clk1();
        rst = 1'b0;
    endtask

    always @(posedge clk) nedges++;

    // Monitor: every duty change and every done pulse must be expected
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_DC !== last_dc) begin
                if (ev_q.size() == 0) begin
                    chk("dc_unexpected", int'(o_DC), int'(last_dc));
                end else begin
                    chk("dc_value", int'(o_DC), ev_q.pop_front());
                    chk("dc_edge", nedges - 1, ee_q.pop_front());
                end
                last_dc = o_DC;
            end
            if (done !== 1'b0) begin
                if (done_q.size() == 0) chk("done_unexpected", int'(done), 0);
                else                    chk("done_edge", nedges - 1, done_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int r, td, cut;
        rst        = 1'b1;
        en         = 1'b1;
        tgt_valid  = 1'b0;
        tgt_duty   = '0;
        step       = '0;
        interval   = '0;
        period_reg = '0;

        do_reset(9, 3);
        last_dc = o_DC;
        mon_en  = 1'b1;

        issue(8, 2, 1, 0, 0);          // 2,4,6,8 on ticks ten cycles apart
        chk("busy_hold", int'(busy), 0);
        chk("valid_hold", int'(o_DC_valid), 1);
        issue(8, 2, 1, 0, 0);          // already there: immediate done
        issue(9, 1, 0, 0, 0);          // interval 0 acts as 1

        do_reset(49, 2);
        issue(40, 10, 1, 0, 0);
        issue(5, 10, 2, 0, 0);         // 30,20,10,5 two periods apart

        do_reset(99, 2);
        issue(150, 0, 1, 0, 0);        // clamped to 99 in one jump

        do_reset(49, 2);
        issue(40, 10, 1, 2, 0);        // interrupted at 20
        issue(0, 10, 1, 0, 0);         // 10,0 then one done
        issue(40, 10, 1, 3, -1);       // next command lands on a step tick
        issue(0, 10, 1, 0, 0);
        issue(40, 10, 1, 3, 0);        // stop at 30
        en_drop(6);
        issue(40, 10, 1, 0, 0);        // resumes from 30
        issue(0, 10, 1, 1, 0);         // abort at 30 by reset
        do_reset(49, 2);

        do_reset(7, 2);
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(9, 0);
            if (r == 0) begin
                do_reset($urandom_range(15, 3), 2);
            end else if (r == 1) begin
                en_drop($urandom_range(5, 1));
            end else begin
                td  = $urandom_range(per + 6, 0);
                cut = ($urandom_range(1, 0) == 1) ? $urandom_range(3 * (per + 1), 1) : 0;
                issue(td, $urandom_range(per / 2, 0), $urandom_range(3, 0), 0, cut);
            end
        end
        issue($urandom_range(per, 0), $urandom_range(per / 2, 1), 1, 0, 0);

        repeat (5) clk1();
        chk("pending_dc", ev_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
